logic_basic_queue_generic: RTL and testbench

// Vendor-independent successor to the scfifo-based basic queue. It is a single-clock
// AXI4-Stream FIFO with first-word-fall-through output. It supports non-power-of-two

---
 rtl/logic_basic_queue_generic_if.sv | 22 ++
 rtl/logic_basic_queue_generic.sv | 144 ++++++++++++++
 tb/tb_logic_basic_queue_generic.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_basic_queue_generic_if.sv
// Stream handshake bundle for the generic basic queue: rx side feeds the queue, tx side drains it.
// The slave modport is the queue's view and the master modport is the surrounding logic's view.
interface logic_basic_queue_generic_if #(
    parameter int WIDTH = 1
);
    logic             rx_tvalid;
    logic [WIDTH-1:0] rx_tdata;
    logic             rx_tready;
    logic             tx_tvalid;
    logic [WIDTH-1:0] tx_tdata;
    logic             tx_tready;

    modport slave (
        input  rx_tvalid, rx_tdata, tx_tready,
        output rx_tready, tx_tvalid, tx_tdata
    );

    modport master (
        output rx_tvalid, rx_tdata, tx_tready,
        input  rx_tready, tx_tvalid, tx_tdata
    );
endinterface

// File: rtl/logic_basic_queue_generic.sv
// Single-clock first-word-fall-through stream FIFO: a (CAPACITY-1)-entry RAM in front of a one-entry
// output register, with arbitrary depth, level reporting, almost-full/almost-empty flags and flush.
module logic_basic_queue_generic #(
    parameter  int WIDTH        = 1,
    parameter  int CAPACITY     = 256,
    parameter  int ALMOST_FULL  = CAPACITY - 1,
    parameter  int ALMOST_EMPTY = 1,
    localparam int LEVEL_WIDTH  = $clog2(CAPACITY + 1)
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic                       flush,
    logic_basic_queue_generic_if.slave q_if,
    output logic [LEVEL_WIDTH-1:0]     level,
    output logic                       almost_full,
    output logic                       almost_empty
);
    localparam int RAM_DEPTH = CAPACITY - 1;
    localparam int PTR_WIDTH = $clog2(RAM_DEPTH);
    localparam logic [PTR_WIDTH-1:0]   PTR_LAST = PTR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [LEVEL_WIDTH-1:0] CAP_LVL  = LEVEL_WIDTH'(CAPACITY);
    localparam logic [LEVEL_WIDTH-1:0] AF_LVL   = LEVEL_WIDTH'(ALMOST_FULL);
    localparam logic [LEVEL_WIDTH-1:0] AE_LVL   = LEVEL_WIDTH'(ALMOST_EMPTY);

    typedef enum logic {
        OUT_EMPTY,
        OUT_VALID
    } out_state_t;

    logic [WIDTH-1:0] mem [0:RAM_DEPTH-1];

    out_state_t             state_reg;
    logic [PTR_WIDTH-1:0]   wr_ptr_reg;
    logic [PTR_WIDTH-1:0]   rd_ptr_reg;
    logic [LEVEL_WIDTH-1:0] ram_count_reg;
    logic [LEVEL_WIDTH-1:0] level_reg;
    logic [LEVEL_WIDTH-1:0] level_next;
    logic                   rx_tready_reg;
    logic                   tx_tvalid_reg;
    logic [WIDTH-1:0]       tx_tdata_reg;
    logic                   almost_full_reg;
    logic                   almost_empty_reg;

    logic wr_en;
    logic pop_en;
    logic out_free;
    logic ram_empty;
    logic ram_load;
    logic bypass;
    logic ram_wr;

    // Depth need not be a power of two, so pointers wrap by explicit compare.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_comb begin
        wr_en     = q_if.rx_tvalid && rx_tready_reg;
        pop_en    = tx_tvalid_reg && q_if.tx_tready;
        out_free  = (state_reg == OUT_EMPTY) || pop_en;
        ram_empty = (ram_count_reg == '0);
        ram_load  = out_free && !ram_empty;
        bypass    = out_free && ram_empty && wr_en;
        ram_wr    = wr_en && !bypass;
        if (flush) begin
            level_next = '0;
        end else begin
            level_next = level_reg + LEVEL_WIDTH'(wr_en) - LEVEL_WIDTH'(pop_en);
        end
    end

    always_ff @(posedge aclk) begin
        if (ram_wr && !flush) begin
            mem[wr_ptr_reg] <= q_if.rx_tdata;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_reg        <= OUT_EMPTY;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            ram_count_reg    <= '0;
            level_reg        <= '0;
            rx_tready_reg    <= 1'b0;
            tx_tvalid_reg    <= 1'b0;
            tx_tdata_reg     <= '0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
        end else begin
            // Status flags all follow level_next so they change on the same edge as level.
            level_reg        <= level_next;
            rx_tready_reg    <= (level_next < CAP_LVL);
            almost_full_reg  <= (level_next >= AF_LVL);
            almost_empty_reg <= (level_next <= AE_LVL);
            if (flush) begin
                state_reg     <= OUT_EMPTY;
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                ram_count_reg <= '0;
                tx_tvalid_reg <= 1'b0;
            end else begin
                if (ram_wr) begin
                    wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                end
                if (ram_load) begin
                    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                end
                ram_count_reg <= ram_count_reg + LEVEL_WIDTH'(ram_wr) - LEVEL_WIDTH'(ram_load);
                if (ram_load) begin
                    tx_tdata_reg <= mem[rd_ptr_reg];
                end else if (bypass) begin
                    tx_tdata_reg <= q_if.rx_tdata;
                end
                case (state_reg)
                    OUT_EMPTY: begin
                        if (ram_load || bypass) begin
                            state_reg     <= OUT_VALID;
                            tx_tvalid_reg <= 1'b1;
                        end
                    end
                    OUT_VALID: begin
                        if (pop_en && !ram_load && !bypass) begin
                            state_reg     <= OUT_EMPTY;
                            tx_tvalid_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg     <= OUT_EMPTY;
                        tx_tvalid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q_if.rx_tready = rx_tready_reg;
    assign q_if.tx_tvalid = tx_tvalid_reg;
    assign q_if.tx_tdata  = tx_tdata_reg;
    assign level          = level_reg;
    assign almost_full    = almost_full_reg;
    assign almost_empty   = almost_empty_reg;

endmodule

// File: tb/tb_logic_basic_queue_generic.sv
// Bench for the generic basic queue: a directed vector table and hand sequences on a 5-deep
// instance, plus randomized traffic on 7- and 256-deep instances scored against a word queue.
module tb_logic_basic_queue_generic;
    localparam int CAP_A  = 5;
    localparam int AF_A   = 4;
    localparam int AE_A   = 1;
    localparam int NWORDS = 10000;

    logic aclk = 1'b0;
    logic rst_a_n;
    logic rst_r_n;
    logic flush_a;
    logic [2:0] level_a;
    logic af_a;
    logic ae_a;

    int checks = 0;
    int failures = 0;

    logic [7:0] qa[$];

    always #5 aclk = ~aclk;

    logic_basic_queue_generic_if #(.WIDTH(8)) a_if ();

    logic_basic_queue_generic #(
        .WIDTH(8), .CAPACITY(CAP_A), .ALMOST_FULL(AF_A), .ALMOST_EMPTY(AE_A)
    ) u_dut_a (
        .aclk(aclk), .areset_n(rst_a_n), .flush(flush_a), .q_if(a_if.slave),
        .level(level_a), .almost_full(af_a), .almost_empty(ae_a)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare every output of the 5-deep instance against the contents of qa.
    task automatic chk_a(input string tag);
        int n;
        n = qa.size();
        chk({tag, "_level"}, longint'(level_a), n);
        chk({tag, "_tvalid"}, longint'(a_if.tx_tvalid), (n > 0) ? 1 : 0);
        if (n > 0) chk({tag, "_tdata"}, longint'(a_if.tx_tdata), longint'(qa[0]));
        chk({tag, "_rready"}, longint'(a_if.rx_tready), (n < CAP_A) ? 1 : 0);
        chk({tag, "_afull"}, longint'(af_a), (n >= AF_A) ? 1 : 0);
        chk({tag, "_aempty"}, longint'(ae_a), (n <= AE_A) ? 1 : 0);
    endtask

    task automatic step_a(input bit fl, input bit v, input logic [7:0] d, input bit r, input string tag);
        bit wr;
        bit pp;
        @(negedge aclk);
        flush_a = fl;
        a_if.rx_tvalid = v;
        a_if.rx_tdata = d;
        a_if.tx_tready = r;
        wr = v && (qa.size() < CAP_A);
        pp = r && (qa.size() > 0);
        if (fl) begin
            qa.delete();
        end else begin
            if (pp) void'(qa.pop_front());
            if (wr) qa.push_back(d);
        end
        @(posedge aclk);
        #1;
        chk_a(tag);
    endtask

    typedef struct {
        bit         fl;
        bit         v;
        logic [7:0] d;
        bit         r;
        bit         e_rxr;
        bit         e_txv;
        logic [7:0] e_txd;
        int         e_lvl;
        bit         e_af;
        bit         e_ae;
    } vec_t;

    function automatic vec_t mk(input bit fl, input bit v, input int d, input bit r, input bit rxr,
                                input bit txv, input int txd, input int lvl, input bit af, input bit ae);
        vec_t t;
        t.fl = fl; t.v = v; t.d = 8'(d); t.r = r;
        t.e_rxr = rxr; t.e_txv = txv; t.e_txd = 8'(txd); t.e_lvl = lvl; t.e_af = af; t.e_ae = ae;
        return t;
    endfunction

    // Randomized traffic on two more depths, each with its own word-queue scoreboard.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rand
        localparam int CAP = (gi == 0) ? 7 : 256;
        localparam int AF  = CAP - 2;
        localparam int AE  = 2;
        localparam int LW  = $clog2(CAP + 1);

        logic_basic_queue_generic_if #(.WIDTH(8)) r_if ();
        logic [LW-1:0] r_level;
        logic r_af;
        logic r_ae;
        bit done = 1'b0;

        logic_basic_queue_generic #(
            .WIDTH(8), .CAPACITY(CAP), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
        ) u_dut (
            .aclk(aclk), .areset_n(rst_r_n), .flush(1'b0), .q_if(r_if.slave),
            .level(r_level), .almost_full(r_af), .almost_empty(r_ae)
        );

        initial begin : rand_proc
            logic [7:0] q[$];
            int pushed;
            int cycles;
            int lvl;
            bit v;
            bit r;
            logic [7:0] d;
            pushed = 0;
            cycles = 0;
            r_if.rx_tvalid = 1'b0;
            r_if.rx_tdata = '0;
            r_if.tx_tready = 1'b0;
            wait (rst_r_n === 1'b1);
            @(posedge aclk);
            while ((pushed < NWORDS || q.size() > 0) && cycles < 40000) begin
                @(negedge aclk);
                cycles++;
                lvl = q.size();
                chk("rand_level", longint'(r_level), lvl);
                chk("rand_tvalid", longint'(r_if.tx_tvalid), (lvl > 0) ? 1 : 0);
                if (lvl > 0) chk("rand_tdata", longint'(r_if.tx_tdata), longint'(q[0]));
                chk("rand_rready", longint'(r_if.rx_tready), (lvl < CAP) ? 1 : 0);
                chk("rand_afull", longint'(r_af), (lvl >= AF) ? 1 : 0);
                chk("rand_aempty", longint'(r_ae), (lvl <= AE) ? 1 : 0);
                // Alternate phases of slow and fast draining so both depths reach full.
                v = (pushed < NWORDS) && ($urandom_range(0, 3) != 0);
                if (((cycles / 1000) % 2) == 1) r = ($urandom_range(0, 1) != 0);
                else r = ($urandom_range(0, 3) != 0);
                d = 8'($urandom);
                r_if.rx_tvalid = v;
                r_if.rx_tdata = d;
                r_if.tx_tready = r;
                if (r && lvl > 0) void'(q.pop_front());
                if (v && lvl < CAP) begin
                    q.push_back(d);
                    pushed++;
                end
            end
            @(negedge aclk);
            r_if.rx_tvalid = 1'b0;
            r_if.tx_tready = 1'b0;
            chk("rand_words_sent", pushed, NWORDS);
            chk("rand_drained", q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 600000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        rst_a_n = 1'b0;
        rst_r_n = 1'b0;
        flush_a = 1'b0;
        a_if.rx_tvalid = 1'b0;
        a_if.rx_tdata = '0;
        a_if.tx_tready = 1'b0;

        //                fl v  d     r  rxr txv txd   lvl af ae
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'hA5, 1, 1, 1, 8'hA5, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 1, 8'h01, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h02, 0, 1, 1, 8'h01, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 1, 1, 8'h01, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 1, 1, 8'h01, 4, 1, 0));
        vecs.push_back(mk(0, 1, 8'h05, 0, 0, 1, 8'h01, 5, 1, 0));
        vecs.push_back(mk(0, 1, 8'h06, 0, 0, 1, 8'h01, 5, 1, 0));
        vecs.push_back(mk(0, 1, 8'h06, 1, 1, 1, 8'h02, 4, 1, 0));
        vecs.push_back(mk(0, 1, 8'h06, 0, 0, 1, 8'h02, 5, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h03, 4, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h04, 3, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h05, 2, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h06, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h07, 1, 1, 1, 8'h07, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h08, 1, 1, 1, 8'h08, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h09, 0, 1, 1, 8'h08, 2, 0, 0));
        vecs.push_back(mk(1, 1, 8'h0A, 1, 1, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h0B, 0, 1, 1, 8'h0B, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1));

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_rready", longint'(a_if.rx_tready), 0);
        chk("reset_tvalid", longint'(a_if.tx_tvalid), 0);
        chk("reset_tdata", longint'(a_if.tx_tdata), 0);
        chk("reset_level", longint'(level_a), 0);
        chk("reset_afull", longint'(af_a), 0);
        chk("reset_aempty", longint'(ae_a), 1);
        @(negedge aclk);
        rst_a_n = 1'b1;
        rst_r_n = 1'b1;
        @(posedge aclk);
        #1;
        chk("first_edge_rready", longint'(a_if.rx_tready), 1);

        foreach (vecs[i]) begin
            @(negedge aclk);
            flush_a = vecs[i].fl;
            a_if.rx_tvalid = vecs[i].v;
            a_if.rx_tdata = vecs[i].d;
            a_if.tx_tready = vecs[i].r;
            @(posedge aclk);
            #1;
            chk($sformatf("vec%0d_rready", i), longint'(a_if.rx_tready), longint'(vecs[i].e_rxr));
            chk($sformatf("vec%0d_tvalid", i), longint'(a_if.tx_tvalid), longint'(vecs[i].e_txv));
            if (vecs[i].e_txv)
                chk($sformatf("vec%0d_tdata", i), longint'(a_if.tx_tdata), longint'(vecs[i].e_txd));
            chk($sformatf("vec%0d_level", i), longint'(level_a), vecs[i].e_lvl);
            chk($sformatf("vec%0d_afull", i), longint'(af_a), longint'(vecs[i].e_af));
            chk($sformatf("vec%0d_aempty", i), longint'(ae_a), longint'(vecs[i].e_ae));
        end

        // Pointer wrap: keep two words resident while streaming three capacities' worth.
        qa.delete();
        step_a(0, 1, 8'h10, 0, "wrap_pre0");
        step_a(0, 1, 8'h11, 0, "wrap_pre1");
        for (int i = 0; i < 3 * CAP_A; i++) step_a(0, 1, 8'(8'h12 + i), 1, "wrap_stream");
        step_a(0, 0, 8'h00, 1, "wrap_drain0");
        step_a(0, 0, 8'h00, 1, "wrap_drain1");

        // Flush with three words held and a concurrent write; none may reappear.
        step_a(0, 1, 8'h21, 0, "flush_fill0");
        step_a(0, 1, 8'h22, 0, "flush_fill1");
        step_a(0, 1, 8'h23, 0, "flush_fill2");
        step_a(1, 1, 8'h24, 0, "flush_edge");
        step_a(0, 1, 8'h25, 0, "flush_after_wr");
        step_a(0, 0, 8'h00, 1, "flush_after_pop");

        // Asynchronous reset in the middle of a cycle clears the queue immediately.
        step_a(0, 1, 8'h31, 0, "areset_fill0");
        step_a(0, 1, 8'h32, 0, "areset_fill1");
        @(negedge aclk);
        a_if.rx_tvalid = 1'b0;
        a_if.tx_tready = 1'b0;
        #2;
        rst_a_n = 1'b0;
        #1;
        qa.delete();
        chk("areset_level", longint'(level_a), 0);
        chk("areset_tvalid", longint'(a_if.tx_tvalid), 0);
        chk("areset_rready", longint'(a_if.rx_tready), 0);
        chk("areset_aempty", longint'(ae_a), 1);
        @(negedge aclk);
        rst_a_n = 1'b1;
        @(posedge aclk);
        #1;
        chk("areset_release_rready", longint'(a_if.rx_tready), 1);
        step_a(0, 1, 8'h77, 0, "areset_new_wr");
        step_a(0, 0, 8'h00, 1, "areset_new_pop");

        while (!(gen_rand[0].done && gen_rand[1].done)) @(posedge aclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
